sub_counter: RTL and testbench

//   Synchronous presettable binary DOWN counter. It is the counting-direction

---
 rtl/counter_pkg.sv | 26 ++
 rtl/sub_counter_cell.sv | 37 +++
 rtl/sub_counter.sv | 63 ++++++
 tb/tb_sub_counter.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter family (addcounter, sub_counter).
//   CNT_W_DEFAULT : default counter width
//   CNT_W_MAX     : widest counter the helper function accepts
//   cnt_op_t      : per-edge operation chosen by the next-state decode
//   is_terminal() : true at the count's terminal value (MAX going up, 0 going down)
package counter_pkg;

  localparam int unsigned CNT_W_DEFAULT = 4;
  localparam int unsigned CNT_W_MAX     = 32;

  typedef enum logic [1:0] {
    CNT_HOLD = 2'd0,
    CNT_LOAD = 2'd1,
    CNT_STEP = 2'd2
  } cnt_op_t;

  // q is zero-extended to CNT_W_MAX bits; w is the live counter width (< 32).
  function automatic logic is_terminal(input logic [CNT_W_MAX-1:0] q,
                                       input logic                 up,
                                       input int unsigned          w);
    logic [CNT_W_MAX-1:0] max_val;
    max_val = (32'd1 << w) - 32'd1;
    return up ? (q == max_val) : (q == '0);
  endfunction

endpackage

// File: rtl/sub_counter_cell.sv
// One bit of the down counter.
//   clk    : rising-edge clock
//   clr    : asynchronous clear, active-low
//   op     : operation for the coming edge (hold / load / step)
//   d      : parallel load bit
//   bp_in  : borrow propagate in, high when every lower bit is 0
//   q      : registered bit
//   bp_out : borrow propagate out to the next higher bit
// When stepping down, a bit toggles exactly when all lower bits are 0,
// the gate-level form of Q-1.
module sub_counter_cell
  import counter_pkg::*;
(
  input  logic    clk,
  input  logic    clr,
  input  cnt_op_t op,
  input  logic    d,
  input  logic    bp_in,
  output logic    q,
  output logic    bp_out
);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      q <= 1'b0;
    end else begin
      case (op)
        CNT_LOAD: q <= d;
        CNT_STEP: if (bp_in) q <= ~q;
        default:  q <= q;
      endcase
    end
  end

  assign bp_out = bp_in & ~q;

endmodule

// File: rtl/sub_counter.sv
// Synchronous presettable binary down counter (74161-style control set).
//   clk : rising-edge clock
//   clr : asynchronous clear, active-low
//   ld  : synchronous parallel load, active-low (beats counting)
//   p   : count enable P (does not gate bo)
//   t   : count enable T (gates bo, used for cascading)
//   D   : parallel load data
//   Q   : counter state (registered)
//   bo  : borrow out, t & (Q==0), combinational
// Build option: SUB_COUNTER_RELOAD_EN -- a step from Q==0 reloads D instead
// of wrapping to MAX, turning the block into a modulo-(D+1) divider.
// Handshake note: no valid/ready here; every control is level-sampled on
// each rising clk, and bo is valid in the same cycle as Q.
module sub_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ld,
  input  logic             p,
  input  logic             t,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             bo
);

  cnt_op_t        op;
  logic [WIDTH:0] bp;

  // Next-state decode: load > step > hold.
  always_comb begin
    op = CNT_HOLD;
    if (!ld) begin
      op = CNT_LOAD;
    end else if (p && t) begin
      op = CNT_STEP;
`ifdef SUB_COUNTER_RELOAD_EN
      // Terminal count reloads rather than wrapping.
      if (is_terminal(CNT_W_MAX'(Q), 1'b0, WIDTH)) op = CNT_LOAD;
`endif
    end
  end

  assign bp[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sub_counter_cell u_cell (
      .clk    (clk),
      .clr    (clr),
      .op     (op),
      .d      (D[i]),
      .bp_in  (bp[i]),
      .q      (Q[i]),
      .bp_out (bp[i+1])
    );
  end

  // End of the propagate chain is high exactly when Q == 0.
  assign bo = t & bp[WIDTH];

endmodule

// File: tb/tb_sub_counter.sv
// Directed bench for sub_counter: clear, load/count, enables, priority,
// two-stage cascade and the terminal-count behaviour of the selected build.
module tb_sub_counter;

  int checks = 0;
  int errors = 0;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr = 1'b1;
  logic       ld  = 1'b1;
  logic       p   = 1'b0;
  logic       t   = 1'b1;
  logic [3:0] d   = 4'd0;
  logic [3:0] q;
  logic       bo;

  // cascade pair
  logic       cld = 1'b1;
  logic       ce  = 1'b0;
  logic [3:0] lo_q, hi_q;
  logic       lo_bo, hi_bo;

  sub_counter #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .ld(ld), .p(p), .t(t), .D(d), .Q(q), .bo(bo)
  );

  sub_counter #(.WIDTH(4)) u_lo (
    .clk(clk), .clr(clr), .ld(cld), .p(ce), .t(ce), .D(4'h0), .Q(lo_q), .bo(lo_bo)
  );

  sub_counter #(.WIDTH(4)) u_hi (
    .clk(clk), .clr(clr), .ld(cld), .p(lo_bo), .t(lo_bo), .D(4'h1), .Q(hi_q), .bo(hi_bo)
  );

  // driver: advance to just after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] exp_q;
  logic [7:0] exp_c;

  initial begin
    // 1 clear
    clr = 1'b0;
    #2;
    chk("clr_async_q", {4'h0, q}, 8'h00);
    chk("clr_async_bo", {7'h0, bo}, 8'h01);
    step();
    step();
    chk("clr_hold_q", {4'h0, q}, 8'h00);
    #2 clr = 1'b1;
    #1;
    chk("clr_release_q", {4'h0, q}, 8'h00);
    chk("clr_release_bo", {7'h0, bo}, 8'h01);
    step();
    chk("clr_after_edge_q", {4'h0, q}, 8'h00);

    // 2 load 12 then count down through the wrap
    d = 4'b1100; ld = 1'b0;
    step();
    chk("load12_q", {4'h0, q}, 8'h0c);
    chk("load12_bo", {7'h0, bo}, 8'h00);
    ld = 1'b1; p = 1'b1; t = 1'b1;
    exp_q = 4'd12;
    for (int i = 0; i < 14; i++) begin
      step();
      exp_q = exp_q - 4'd1;
      chk("count_q", {4'h0, q}, {4'h0, exp_q});
      chk("count_bo", {7'h0, bo}, {7'h0, (exp_q == 4'd0)});
    end
    chk("count_end_q", {4'h0, q}, 8'h0e);

    // 3 enables
    d = 4'd5; ld = 1'b0;
    step();
    ld = 1'b1; p = 1'b0; t = 1'b1;
    step();
    chk("hold_p0_q", {4'h0, q}, 8'h05);
    chk("hold_p0_bo", {7'h0, bo}, 8'h00);
    p = 1'b1; t = 1'b0;
    step();
    chk("hold_t0_q", {4'h0, q}, 8'h05);
    d = 4'd0; ld = 1'b0;
    step();
    ld = 1'b1; p = 1'b0; t = 1'b0;
    #1;
    chk("zero_t0_bo", {7'h0, bo}, 8'h00);
    t = 1'b1;
    #1;
    chk("zero_t1_bo", {7'h0, bo}, 8'h01);

    // 4 priority: load beats step at Q==0, clear beats load
    d = 4'b0011; ld = 1'b0; p = 1'b1; t = 1'b1;
    #1;
    chk("prio_pre_bo", {7'h0, bo}, 8'h01);
    step();
    chk("prio_load_q", {4'h0, q}, 8'h03);
    chk("prio_load_bo", {7'h0, bo}, 8'h00);
    d = 4'd9; clr = 1'b0;
    #1;
    chk("prio_clr_async_q", {4'h0, q}, 8'h00);
    step();
    chk("prio_clr_edge_q", {4'h0, q}, 8'h00);
    clr = 1'b1; ld = 1'b1; p = 1'b0;
    step();

    // 5 cascade: two digits loaded 8'h10, 17 edges down to 8'hFF
    cld = 1'b0;
    step();
    chk("casc_load", {hi_q, lo_q}, 8'h10);
    cld = 1'b1; ce = 1'b1;
    exp_c = 8'h10;
    for (int i = 0; i < 17; i++) begin
      step();
      exp_c = exp_c - 8'd1;
      chk("casc_q", {hi_q, lo_q}, exp_c);
      chk("casc_hi_bo", {7'h0, hi_bo}, {7'h0, (exp_c == 8'h00)});
    end
    chk("casc_end", {hi_q, lo_q}, 8'hff);
    ce = 1'b0;

    // 6 terminal count behaviour with D=2
    d = 4'd2; ld = 1'b0; p = 1'b1; t = 1'b1;
    step();
    chk("term_load_q", {4'h0, q}, 8'h02);
    ld = 1'b1;
    step();
    chk("term_q1", {4'h0, q}, 8'h01);
    step();
    chk("term_q0", {4'h0, q}, 8'h00);
    chk("term_bo", {7'h0, bo}, 8'h01);
    step();
`ifdef SUB_COUNTER_RELOAD_EN
    chk("term_next_q", {4'h0, q}, 8'h02);
    step();
    chk("term_next2_q", {4'h0, q}, 8'h01);
    step();
    chk("term_next3_q", {4'h0, q}, 8'h00);
`else
    chk("term_next_q", {4'h0, q}, 8'h0f);
    step();
    chk("term_next2_q", {4'h0, q}, 8'h0e);
    step();
    chk("term_next3_q", {4'h0, q}, 8'h0d);
`endif

    // report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
